// File: rtl/rom_ram_bus_pkg.sv
// -----------------------------------------------------------------------------
// rom_ram_bus_pkg
// Shared definitions for the blocks that sit on the 4-bit multiplexed
// instruction bus (4001-style ROM and 4002-style RAM).
//   - bus_cycle_t      : 3-bit bus phase index
//   - CYC_A1 .. CYC_X3 : phase encoding driven by bus_cycle_counter
//   - OP_WRR, OP_RDR   : port-instruction opcodes captured during M2
//   - chip_match()     : compares a bus nibble against a chip number
// -----------------------------------------------------------------------------
package rom_ram_bus_pkg;

   typedef logic [2:0] bus_cycle_t;

   localparam bus_cycle_t CYC_A1 = 3'd0;
   localparam bus_cycle_t CYC_A2 = 3'd1;
   localparam bus_cycle_t CYC_A3 = 3'd2;
   localparam bus_cycle_t CYC_M1 = 3'd3;
   localparam bus_cycle_t CYC_M2 = 3'd4;
   localparam bus_cycle_t CYC_X1 = 3'd5;
   localparam bus_cycle_t CYC_X2 = 3'd6;
   localparam bus_cycle_t CYC_X3 = 3'd7;

   localparam logic [3:0] OP_WRR = 4'h2;
   localparam logic [3:0] OP_RDR = 4'hA;

   // True when the nibble on the bus names this chip.
   function automatic logic chip_match(input logic [3:0] nibble, input logic [3:0] chip_id);
      return (nibble == chip_id);
   endfunction

endpackage

// File: rtl/bus_cycle_counter.sv
// -----------------------------------------------------------------------------
// bus_cycle_counter
// Free-running 3-bit bus phase counter (A1..X3), wrapping 7 -> 0.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset, forces phase A1
//   cycle   : current bus phase (registered)
// -----------------------------------------------------------------------------
module bus_cycle_counter
   import rom_ram_bus_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   output bus_cycle_t cycle
);

   bus_cycle_t cycle_r;

   // Phase counter: advances one phase per clock, natural 3-bit wrap.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cycle_r <= CYC_A1;
      end else begin
         cycle_r <= cycle_r + 3'd1;
      end
   end

   assign cycle = cycle_r;

endmodule

// File: rtl/rom_4001.sv
// -----------------------------------------------------------------------------
// rom_4001
// 256-byte program ROM with a 4-bit I/O port on the shared multiplexed bus.
// Ports:
//   clock     : system clock, all state on rising edge
//   reset_n   : synchronous active-low reset (memory contents kept)
//   data      : shared 4-bit bus, high-Z unless this chip drives it
//   sync      : bus sync, accepted but not used for alignment
//   cmd_n     : active-low ROM command line
//   port_in   : input port, driven onto the bus by RDR during X2
//   port_out  : registered output port, loaded by WRR at end of X2
//   prog_we   : program-load write enable
//   prog_addr : program-load byte address
//   prog_data : program-load byte
// -----------------------------------------------------------------------------
module rom_4001
   import rom_ram_bus_pkg::*;
#(
   parameter logic [3:0] CHIP_ID = 4'h0,
   parameter int         DEPTH   = 256
)
(
   input  logic       clock,
   input  logic       reset_n,
   inout  wire  [3:0] data,
   input  logic       sync,
   input  logic       cmd_n,
   input  logic [3:0] port_in,
   output logic [3:0] port_out,
   input  logic       prog_we,
   input  logic [7:0] prog_addr,
   input  logic [7:0] prog_data
);

   bus_cycle_t cycle_s;
   logic       cmd_s;
   logic [7:0] fetch_byte_s;
   logic       drive_en_s;
   logic [3:0] drive_val_s;
   logic       bus_unused_s;

   logic [7:0] mem_r [0:DEPTH-1];
   logic [3:0] addr_lo_r;
   logic [3:0] addr_hi_r;
   logic       rom_sel_r;
   logic       io_sel_r;
   logic       src_pending_r;
   logic [3:0] inst_r;
   logic       inst_active_r;
   logic [3:0] port_out_r;

   bus_cycle_counter u_cycle (
      .clock   (clock),
      .reset_n (reset_n),
      .cycle   (cycle_s)
   );

   assign cmd_s        = ~cmd_n;
   assign fetch_byte_s = mem_r[{addr_hi_r, addr_lo_r}];
   // sync and src_pending carry no behaviour in this chip; kept for bus parity.
   assign bus_unused_s = sync ^ src_pending_r;

   // Program store: not reset, so contents survive reset; loads allowed any time.
   always_ff @(posedge clock) begin
      if (prog_we) begin
         mem_r[prog_addr] <= prog_data;
      end
   end

   // Bus-phase control: address latch, chip selects, port instruction and port.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         addr_lo_r     <= 4'h0;
         addr_hi_r     <= 4'h0;
         rom_sel_r     <= 1'b0;
         io_sel_r      <= 1'b0;
         src_pending_r <= 1'b0;
         inst_r        <= 4'h0;
         inst_active_r <= 1'b0;
         port_out_r    <= 4'h0;
      end else begin
         case (cycle_s)
            CYC_A1: addr_lo_r <= data;
            CYC_A2: addr_hi_r <= data;
            CYC_A3: rom_sel_r <= cmd_s & chip_match(data, CHIP_ID);
            CYC_M2: begin
               if (cmd_s && io_sel_r) begin
                  inst_r        <= data;
                  inst_active_r <= 1'b1;
               end
            end
            CYC_X2: begin
               // SRC: a chip-number miss deselects the port, a hit selects it.
               if (cmd_s) begin
                  if (chip_match(data, CHIP_ID)) begin
                     io_sel_r      <= 1'b1;
                     src_pending_r <= 1'b1;
                  end else begin
                     io_sel_r <= 1'b0;
                  end
               end
               if (inst_active_r && (inst_r == OP_WRR)) begin
                  port_out_r <= data;
               end
            end
            CYC_X3: begin
               src_pending_r <= 1'b0;
               inst_active_r <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Bus drive select: fetch (M1/M2) and RDR (X2) never overlap; reset forces release.
   always_comb begin
      drive_en_s  = 1'b0;
      drive_val_s = 4'h0;
      if (!reset_n) begin
         drive_en_s  = 1'b0;
         drive_val_s = 4'h0;
      end else begin
         case (cycle_s)
            CYC_M1: begin
               if (rom_sel_r) begin
                  drive_en_s  = 1'b1;
                  drive_val_s = fetch_byte_s[7:4];
               end else begin
                  drive_en_s  = 1'b0;
               end
            end
            CYC_M2: begin
               if (rom_sel_r) begin
                  drive_en_s  = 1'b1;
                  drive_val_s = fetch_byte_s[3:0];
               end else begin
                  drive_en_s  = 1'b0;
               end
            end
            CYC_X2: begin
               if (inst_active_r && (inst_r == OP_RDR)) begin
                  drive_en_s  = 1'b1;
                  drive_val_s = port_in;
               end else begin
                  drive_en_s  = 1'b0;
               end
            end
            default: begin
               drive_en_s = 1'b0;
            end
         endcase
      end
   end

   assign data     = drive_en_s ? drive_val_s : 4'bzzzz;
   assign port_out = port_out_r;

endmodule

// File: tb/tb_rom_4001.sv
// -----------------------------------------------------------------------------
// tb_rom_4001
// Frame-level bench for rom_4001 with CHIP_ID=3. The bus is a pulled-up net,
// so a released bus reads as 4'hF; none of the driven test values is 4'hF.
// -----------------------------------------------------------------------------
module tb_rom_4001;

   localparam logic [3:0] IDLE = 4'hF;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       sync;
   logic       cmd_n;
   logic [3:0] port_in;
   logic [3:0] port_out;
   logic       prog_we;
   logic [7:0] prog_addr;
   logic [7:0] prog_data;
   logic       tb_en;
   logic [3:0] tb_val;
   tri1  [3:0] data;

   assign data = tb_en ? tb_val : 4'bzzzz;

   always #5 clock = ~clock;

   rom_4001 #(.CHIP_ID(4'h3), .DEPTH(256)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .data      (data),
      .sync      (sync),
      .cmd_n     (cmd_n),
      .port_in   (port_in),
      .port_out  (port_out),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data)
   );

   typedef struct {
      string      name;
      logic [3:0] a1, a2, a3;
      logic       a3_cmd;
      logic       m1_load;
      logic [7:0] load_byte;
      logic       m2_drv;
      logic [3:0] m2_val;
      logic       m2_cmd;
      logic       x2_drv;
      logic [3:0] x2_val;
      logic       x2_cmd;
      logic [3:0] exp_m1, exp_m2, exp_x2, exp_port;
   } frame_t;

   typedef struct {
      string      name;
      logic       is_port;
      logic [3:0] exp;
   } exp_t;

   exp_t       exp_q[$];
   frame_t     frames[15];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] port_model = 4'h0;

   function automatic frame_t mk(input string n,
                                 input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                                 input logic a3c, input logic ld, input logic [7:0] lb,
                                 input logic m2d, input logic [3:0] m2v, input logic m2c,
                                 input logic x2d, input logic [3:0] x2v, input logic x2c,
                                 input logic [3:0] e1, input logic [3:0] e2,
                                 input logic [3:0] ex, input logic [3:0] ep);
      frame_t f;
      f.name = n; f.a1 = a1; f.a2 = a2; f.a3 = a3; f.a3_cmd = a3c;
      f.m1_load = ld; f.load_byte = lb;
      f.m2_drv = m2d; f.m2_val = m2v; f.m2_cmd = m2c;
      f.x2_drv = x2d; f.x2_val = x2v; f.x2_cmd = x2c;
      f.exp_m1 = e1; f.exp_m2 = e2; f.exp_x2 = ex; f.exp_port = ep;
      return f;
   endfunction

   task automatic push_exp(input string n, input logic is_port, input logic [3:0] v);
      exp_t e;
      e.name = n; e.is_port = is_port; e.exp = v;
      exp_q.push_back(e);
   endtask

   // Drive one bus phase at a falling edge, queue expectations, compare, advance.
   task automatic phase_step(input logic en, input logic [3:0] val, input logic cmd,
                             input string tag,
                             input logic chk_bus, input logic [3:0] exp_bus,
                             input logic chk_port, input logic [3:0] exp_port);
      exp_t       e;
      logic [3:0] act;
      tb_en  = en;
      tb_val = val;
      cmd_n  = ~cmd;
      if (chk_bus)  push_exp({tag, "/bus"}, 1'b0, exp_bus);
      if (chk_port) push_exp({tag, "/port"}, 1'b1, exp_port);
      #1;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = e.is_port ? port_out : data;
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: actual %h, required %h", e.name, act, e.exp);
         end
      end
      @(negedge clock);
   endtask

   task automatic run_frame(input frame_t f);
      reset_n = 1'b1;
      phase_step(1'b1, f.a1, 1'b0, {f.name, "/a1"}, 1'b0, 4'h0, 1'b1, port_model);
      phase_step(1'b1, f.a2, 1'b0, {f.name, "/a2"}, 1'b0, 4'h0, 1'b0, 4'h0);
      phase_step(1'b1, f.a3, f.a3_cmd, {f.name, "/a3"}, 1'b0, 4'h0, 1'b0, 4'h0);
      prog_we   = f.m1_load;
      prog_addr = 8'h5C;
      prog_data = f.load_byte;
      phase_step(1'b0, 4'h0, 1'b0, {f.name, "/m1"}, 1'b1, f.exp_m1, 1'b0, 4'h0);
      prog_we   = 1'b0;
      phase_step(f.m2_drv, f.m2_val, f.m2_cmd, {f.name, "/m2"}, ~f.m2_drv, f.exp_m2, 1'b0, 4'h0);
      phase_step(1'b0, 4'h0, 1'b0, {f.name, "/x1"}, 1'b1, IDLE, 1'b0, 4'h0);
      phase_step(f.x2_drv, f.x2_val, f.x2_cmd, {f.name, "/x2"}, ~f.x2_drv, f.exp_x2, 1'b1, port_model);
      port_model = f.exp_port;
      phase_step(1'b0, 4'h0, 1'b0, {f.name, "/x3"}, 1'b1, IDLE, 1'b1, port_model);
   endtask

   initial begin
      //                  name            a1    a2    a3    a3c   ld    lbyte  m2d   m2v   m2c   x2d   x2v   x2c   m1    m2    x2    port
      frames[0]  = mk("fetch_hit",       4'hC, 4'h5, 4'h3, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 4'h7, IDLE, 4'h0);
      frames[1]  = mk("miss_id",         4'hC, 4'h5, 4'h2, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, IDLE, IDLE, IDLE, 4'h0);
      frames[2]  = mk("miss_cmd",        4'hC, 4'h5, 4'h3, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, IDLE, IDLE, IDLE, 4'h0);
      frames[3]  = mk("src3",            4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1, 4'h3, 1'b1, IDLE, IDLE, IDLE, 4'h0);
      frames[4]  = mk("wrr9",            4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h2, 1'b1, 1'b1, 4'h9, 1'b0, IDLE, IDLE, IDLE, 4'h9);
      frames[5]  = mk("src1",            4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, IDLE, IDLE, IDLE, 4'h9);
      frames[6]  = mk("wrr_unsel",       4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h2, 1'b1, 1'b1, 4'h5, 1'b0, IDLE, IDLE, IDLE, 4'h9);
      frames[7]  = mk("src3b",           4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1, 4'h3, 1'b1, IDLE, IDLE, IDLE, 4'h9);
      frames[8]  = mk("rdr",             4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0, IDLE, IDLE, 4'h6, 4'h9);
      frames[9]  = mk("nop_inst",        4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 1'b0, IDLE, IDLE, IDLE, 4'h9);
      frames[10] = mk("wrr_persist",     4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h2, 1'b1, 1'b1, 4'hC, 1'b0, IDLE, IDLE, IDLE, 4'hC);
      frames[11] = mk("post_rst_wrr",    4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h2, 1'b1, 1'b1, 4'h5, 1'b0, IDLE, IDLE, IDLE, 4'h0);
      frames[12] = mk("refetch",         4'hC, 4'h5, 4'h3, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 4'h7, IDLE, 4'h0);
      frames[13] = mk("collision",       4'hC, 4'h5, 4'h3, 1'b1, 1'b1, 8'h3E, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 4'hE, IDLE, 4'h0);
      frames[14] = mk("fetch_new",       4'hC, 4'h5, 4'h3, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h3, 4'hE, IDLE, 4'h0);

      // Reset with a program load in flight: load is legal during reset.
      reset_n   = 1'b0;
      sync      = 1'b0;
      cmd_n     = 1'b1;
      tb_en     = 1'b0;
      tb_val    = 4'h0;
      port_in   = 4'h6;
      prog_we   = 1'b1;
      prog_addr = 8'h5C;
      prog_data = 8'hA7;
      @(negedge clock);
      prog_we = 1'b0;
      phase_step(1'b0, 4'h0, 1'b0, "reset", 1'b1, IDLE, 1'b1, 4'h0);

      for (int i = 0; i < 11; i++) begin
         run_frame(frames[i]);
      end

      // Reset asserted in M1 of a selected fetch: bus releases immediately,
      // port clears on the reset edge and the counter restarts at A1.
      reset_n = 1'b1;
      phase_step(1'b1, 4'hC, 1'b0, "midrst/a1", 1'b0, 4'h0, 1'b0, 4'h0);
      phase_step(1'b1, 4'h5, 1'b0, "midrst/a2", 1'b0, 4'h0, 1'b0, 4'h0);
      phase_step(1'b1, 4'h3, 1'b1, "midrst/a3", 1'b0, 4'h0, 1'b0, 4'h0);
      reset_n = 1'b0;
      phase_step(1'b0, 4'h0, 1'b0, "midrst/m1", 1'b1, IDLE, 1'b1, 4'hC);
      phase_step(1'b0, 4'h0, 1'b0, "midrst/held", 1'b1, IDLE, 1'b1, 4'h0);
      port_model = 4'h0;

      for (int i = 11; i < 15; i++) begin
         run_frame(frames[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_4001.md
Name: rom_4001

Overview:
- 4001-style program ROM plus 4-bit I/O port on the shared 4-bit multiplexed bus.
- Sits upstream of the CPU, on the same bus as the 4002 RAM block.
- During A1-A3 it latches the 12-bit fetch address and checks the chip-select nibble.
- During M1/M2 it drives the selected instruction byte, high nibble first.
- During X2 it services SRC-selected port instructions: WRR latches the output port, RDR drives the input port onto the bus.

Parameters:
- CHIP_ID, 4'h0, chip number; matched against the A3 nibble and the SRC X2 nibble.
- DEPTH, 256, program bytes per chip; fixed at 256 because the address is 8 bits.

Ports:
- clock  input  1  single system clock, all state on rising edge
- reset_n  input  1  synchronous, active-low reset
- data  inout  4  shared multiplexed bus; high-Z unless this chip drives it
- sync  input  1  bus sync; accepted for bus compatibility, not used for cycle alignment
- cmd_n  input  1  active-low ROM command line
- port_in  input  4  external input port, sampled combinationally for RDR
- port_out  output  4  registered output port
- prog_we  input  1  program-load write enable
- prog_addr  input  8  program-load byte address
- prog_data  input  8  program-load byte

Behaviour:
- Bus cycle counter:
  - 3-bit, reset to 0, increments every clock and wraps 7 -> 0.
  - Phase encoding: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
- Address latch:
  - A1: addr_lo <= data.
  - A2: addr_hi <= data.
  - A3: rom_sel <= (cmd asserted and data == CHIP_ID); otherwise rom_sel <= 0.
- Fetch drive (combinational):
  - M1 with rom_sel: data = mem[{addr_hi,addr_lo}][7:4].
  - M2 with rom_sel: data = mem[{addr_hi,addr_lo}][3:0].
  - All other cases: high-Z.
- SRC:
  - X2 with cmd: if data == CHIP_ID then io_sel <= 1 and src_pending <= 1; else io_sel <= 0.
  - X3: src_pending <= 0. The X3 nibble is the RAM character address and is ignored here.
- Port instruction capture:
  - M2 with cmd and io_sel: inst <= data, inst_active <= 1.
  - X3 of every frame: inst_active <= 0.
- X2 execute, only when inst_active:
  - inst==4'h2 (WRR): port_out <= data at the end of X2.
  - inst==4'hA (RDR): data = port_in during X2.
  - Any other inst: no action, bus stays high-Z.
- Bus drive priority:
  - Fetch drive and RDR occur in disjoint phases; at most one drive source is ever active.
  - The block never drives during A1-A3, X1, or X3.
- Program load:
  - prog_we writes mem[prog_addr] <= prog_data on the clock edge.
  - Write has priority; a same-cycle read returns the old byte, the next cycle returns the new byte.
  - Program load is legal during reset.
- Reset values:
  - Cleared: cycle=0, addr=0, rom_sel=0, io_sel=0, src_pending=0, inst=0, inst_active=0, port_out=0, data=high-Z.
  - Memory contents are preserved across reset.
- Reset mid-frame aborts the frame: no drive and no port write until a fresh A3/SRC select.
- io_sel persists across frames until the next SRC, which can clear it.
- rom_sel is re-evaluated every A3.

Decomposition:
- Shared package (rom_ram_bus_pkg):
  - Phase constants CYC_A1..CYC_X3.
  - Opcode constants OP_WRR=4'h2, OP_RDR=4'hA.
  - Common with the RAM block.
- Sub-module bus_cycle_counter: 3-bit phase counter with synchronous active-low reset, reusable by the RAM block.

Test Plan:
- Fetch hit: CHIP_ID=3, load mem[8'h5C]=8'hA7; drive A1=C, A2=5, A3=3 with cmd -> M1 shows 4'hA, M2 shows 4'h7, all other phases high-Z.
- Fetch miss: same frame but A3=2 -> bus high-Z for the entire frame; repeat with A3=3 and cmd_n=1 -> also high-Z.
- WRR: SRC with X2=3 and cmd; next frame M2 cmd nibble=2, X2 data=9 -> port_out==4'h9 from the X3 edge on; repeat with SRC X2=1 -> port_out unchanged.
- RDR: port_in=4'h6, SRC selects chip 3, M2 inst=A -> bus==4'h6 during X2 only, high-Z in X3.
- Reset mid-frame: reset_n low during M1 of a selected fetch -> bus high-Z at once, port_out=0, cycle=0; mem[8'h5C] still 8'hA7 on re-fetch.
- Program-load collision: prog_we writes mem[8'h5C]=8'h3E in the same cycle as M1 -> M1 drives old 4'hA, M2 drives new 4'hE.
